// File: rtl/gato_game_ctrl.sv
// ---------------------------------------------------------------------------
// gato_game_ctrl
// N x N, K-in-a-row game controller. Owns the board, cursor, turn tracking,
// per-turn timeout and registered win/draw detection. Every output is driven
// straight from a flop.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_mover      1-cycle pulse: advance cursor (wraps N*N-1 -> 0)
//   i_colocar    1-cycle pulse: place current player's mark at cursor
//   i_nuevo      1-cycle pulse: synchronous new game, highest priority
//   o_board      cell i at [2i+1:2i], row-major; 00 empty, 01 X, 10 O
//   o_cursor     current cell index
//   o_jugador    player to move: 1 = X, 0 = O
//   o_win        K-in-a-row present (held)
//   o_draw       board full with no win (held)
//   o_winner     winning mark (01/10), 00 otherwise
//   o_game_over  high while locked in OVER
//   o_timeout    1-cycle pulse when a turn expires
//   o_illegal    1-cycle pulse when colocar targets an occupied cell
// ---------------------------------------------------------------------------
module gato_game_ctrl #(
    parameter int unsigned N           = 3,
    parameter int unsigned K           = 3,
    parameter int unsigned TURN_CYCLES = 1000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_mover,
    input  logic                     i_colocar,
    input  logic                     i_nuevo,
    output logic [2*N*N-1:0]         o_board,
    output logic [$clog2(N*N)-1:0]   o_cursor,
    output logic                     o_jugador,
    output logic                     o_win,
    output logic                     o_draw,
    output logic [1:0]               o_winner,
    output logic                     o_game_over,
    output logic                     o_timeout,
    output logic                     o_illegal
);

    localparam int unsigned CELLS = N * N;
    localparam int unsigned CW    = $clog2(CELLS);
    localparam int unsigned TW    = $clog2(TURN_CYCLES);

    typedef enum logic [1:0] {
        StPlay  = 2'd0,
        StCheck = 2'd1,
        StOver  = 2'd2
    } state_e;

    state_e                  r_state, w_state_nxt;
    logic [CELLS-1:0][1:0]   r_board, w_board_nxt;
    logic [CW-1:0]           r_cursor, w_cursor_nxt;
    logic                    r_jugador, w_jugador_nxt;
    logic [TW-1:0]           r_timer, w_timer_nxt;
    logic                    r_win, w_win_nxt;
    logic                    r_draw, w_draw_nxt;
    logic [1:0]              r_winner, w_winner_nxt;
    logic                    r_timeout, w_timeout_nxt;
    logic                    r_illegal, w_illegal_nxt;

    logic                    w_win;
    logic                    w_full;
    logic                    w_cell_empty;
    logic                    w_place;
    logic                    w_expired;
    logic [1:0]              w_mark;
    logic [4*CELLS-1:0]      w_hits;

    // ------------------------------------------------------------------
    // Win detection: one hit bit per (start cell, direction). Windows that
    // would run off the board are tied low.
    // ------------------------------------------------------------------
    for (genvar gr = 0; gr < N; gr++) begin : g_r
        for (genvar gc = 0; gc < N; gc++) begin : g_c
            localparam int unsigned Idx = gr * N + gc;
            logic [K-1:0] w_h, w_v, w_d, w_a;
            for (genvar gk = 0; gk < K; gk++) begin : g_k
                if (gc + K <= N) begin : g_h
                    assign w_h[gk] = (r_board[gr*N + gc + gk] == r_board[Idx]);
                end else begin : g_h_off
                    assign w_h[gk] = 1'b0;
                end
                if (gr + K <= N) begin : g_v
                    assign w_v[gk] = (r_board[(gr + gk)*N + gc] == r_board[Idx]);
                end else begin : g_v_off
                    assign w_v[gk] = 1'b0;
                end
                if ((gr + K <= N) && (gc + K <= N)) begin : g_d
                    assign w_d[gk] = (r_board[(gr + gk)*N + gc + gk] == r_board[Idx]);
                end else begin : g_d_off
                    assign w_d[gk] = 1'b0;
                end
                if ((gr + K <= N) && (gc + 1 >= K)) begin : g_a
                    assign w_a[gk] = (r_board[(gr + gk)*N + gc - gk] == r_board[Idx]);
                end else begin : g_a_off
                    assign w_a[gk] = 1'b0;
                end
            end
            assign w_hits[4*Idx + 0] = (r_board[Idx] != 2'b00) && (&w_h);
            assign w_hits[4*Idx + 1] = (r_board[Idx] != 2'b00) && (&w_v);
            assign w_hits[4*Idx + 2] = (r_board[Idx] != 2'b00) && (&w_d);
            assign w_hits[4*Idx + 3] = (r_board[Idx] != 2'b00) && (&w_a);
        end
    end

    assign w_win = |w_hits;

    always_comb begin
        w_full = 1'b1;
        for (int i = 0; i < CELLS; i++) begin
            if (r_board[i] == 2'b00) w_full = 1'b0;
        end
    end

    assign w_mark       = r_jugador ? 2'b01 : 2'b10;
    assign w_cell_empty = (r_board[r_cursor] == 2'b00);
    assign w_place      = (r_state == StPlay) && i_colocar && w_cell_empty;
    assign w_expired    = (r_timer == TW'(TURN_CYCLES - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StPlay;
        else          r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StPlay:  if (w_place) w_state_nxt = StCheck;
            StCheck: w_state_nxt = (w_win || w_full) ? StOver : StPlay;
            StOver:  w_state_nxt = StOver;
            default: w_state_nxt = StPlay;
        endcase
        if (i_nuevo) w_state_nxt = StPlay;
    end

    // FSM: datapath / output next values
    always_comb begin
        w_board_nxt   = r_board;
        w_cursor_nxt  = r_cursor;
        w_jugador_nxt = r_jugador;
        w_timer_nxt   = r_timer;
        w_win_nxt     = r_win;
        w_draw_nxt    = r_draw;
        w_winner_nxt  = r_winner;
        w_timeout_nxt = 1'b0;
        w_illegal_nxt = 1'b0;

        case (r_state)
            StPlay: begin
                if (w_place) begin
                    // Placement beats a simultaneous expiry and mover.
                    w_board_nxt[r_cursor] = w_mark;
                    w_timer_nxt           = '0;
                end else begin
                    if (i_colocar) begin
                        w_illegal_nxt = 1'b1;
                    end else if (i_mover) begin
                        w_cursor_nxt = (r_cursor == CW'(CELLS - 1)) ? '0
                                                                    : r_cursor + CW'(1);
                    end
                    if (w_expired) begin
                        w_timer_nxt   = '0;
                        w_jugador_nxt = ~r_jugador;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
            end
            StCheck: begin
                // Only the mark just placed can have completed a line.
                if (w_win) begin
                    w_win_nxt    = 1'b1;
                    w_winner_nxt = w_mark;
                end else if (w_full) begin
                    w_draw_nxt = 1'b1;
                end else begin
                    w_jugador_nxt = ~r_jugador;
                end
            end
            default: ;
        endcase

        if (i_nuevo) begin
            w_board_nxt   = '0;
            w_cursor_nxt  = '0;
            w_jugador_nxt = 1'b1;
            w_timer_nxt   = '0;
            w_win_nxt     = 1'b0;
            w_draw_nxt    = 1'b0;
            w_winner_nxt  = 2'b00;
            w_timeout_nxt = 1'b0;
            w_illegal_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_board   <= '0;
            r_cursor  <= '0;
            r_jugador <= 1'b1;
            r_timer   <= '0;
            r_win     <= 1'b0;
            r_draw    <= 1'b0;
            r_winner  <= 2'b00;
            r_timeout <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_board   <= w_board_nxt;
            r_cursor  <= w_cursor_nxt;
            r_jugador <= w_jugador_nxt;
            r_timer   <= w_timer_nxt;
            r_win     <= w_win_nxt;
            r_draw    <= w_draw_nxt;
            r_winner  <= w_winner_nxt;
            r_timeout <= w_timeout_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign o_board     = r_board;
    assign o_cursor    = r_cursor;
    assign o_jugador   = r_jugador;
    assign o_win       = r_win;
    assign o_draw      = r_draw;
    assign o_winner    = r_winner;
    assign o_game_over = (r_state == StOver);
    assign o_timeout   = r_timeout;
    assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_gato_game_ctrl.sv
module tb_gato_game_ctrl;

  logic clk;
  logic rst_n;

  logic        a_mover, a_colocar, a_nuevo;
  logic [17:0] a_board;
  logic [3:0]  a_cursor;
  logic        a_jugador, a_win, a_draw, a_over, a_timeout, a_illegal;
  logic [1:0]  a_winner;

  logic        b_mover, b_colocar, b_nuevo;
  logic [31:0] b_board;
  logic [3:0]  b_cursor;
  logic        b_jugador, b_win, b_draw, b_over, b_timeout, b_illegal;
  logic [1:0]  b_winner;

  logic        t_mover, t_colocar, t_nuevo;
  logic [17:0] t_board;
  logic [3:0]  t_cursor;
  logic        t_jugador, t_win, t_draw, t_over, t_timeout, t_illegal;
  logic [1:0]  t_winner;

  int n_cmp = 0;
  int n_bad = 0;
  int a_cur = 0;
  int b_cur = 0;
  int t_cur = 0;

  gato_game_ctrl #(.N(3), .K(3), .TURN_CYCLES(1000)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mover(a_mover), .i_colocar(a_colocar), .i_nuevo(a_nuevo),
    .o_board(a_board), .o_cursor(a_cursor), .o_jugador(a_jugador),
    .o_win(a_win), .o_draw(a_draw), .o_winner(a_winner),
    .o_game_over(a_over), .o_timeout(a_timeout), .o_illegal(a_illegal)
  );

  gato_game_ctrl #(.N(4), .K(3), .TURN_CYCLES(1000)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mover(b_mover), .i_colocar(b_colocar), .i_nuevo(b_nuevo),
    .o_board(b_board), .o_cursor(b_cursor), .o_jugador(b_jugador),
    .o_win(b_win), .o_draw(b_draw), .o_winner(b_winner),
    .o_game_over(b_over), .o_timeout(b_timeout), .o_illegal(b_illegal)
  );

  gato_game_ctrl #(.N(3), .K(3), .TURN_CYCLES(8)) u_t (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mover(t_mover), .i_colocar(t_colocar), .i_nuevo(t_nuevo),
    .o_board(t_board), .o_cursor(t_cursor), .o_jugador(t_jugador),
    .o_win(t_win), .o_draw(t_draw), .o_winner(t_winner),
    .o_game_over(t_over), .o_timeout(t_timeout), .o_illegal(t_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic a_mv();
    a_mover = 1'b1; @(negedge clk); a_mover = 1'b0;
    a_cur = (a_cur + 1) % 9;
  endtask
  task automatic a_put(input int c);
    while (a_cur != c) a_mv();
    a_colocar = 1'b1; @(negedge clk); a_colocar = 1'b0;
    @(negedge clk);
  endtask
  task automatic a_new();
    a_nuevo = 1'b1; @(negedge clk); a_nuevo = 1'b0;
    a_cur = 0;
  endtask

  task automatic b_put(input int c);
    while (b_cur != c) begin
      b_mover = 1'b1; @(negedge clk); b_mover = 1'b0;
      b_cur = (b_cur + 1) % 16;
    end
    b_colocar = 1'b1; @(negedge clk); b_colocar = 1'b0;
    @(negedge clk);
  endtask
  task automatic b_new();
    b_nuevo = 1'b1; @(negedge clk); b_nuevo = 1'b0;
    b_cur = 0;
  endtask

  task automatic t_new();
    t_nuevo = 1'b1; @(negedge clk); t_nuevo = 1'b0;
    t_cur = 0;
  endtask

  initial begin
    int seq[9];

    rst_n = 1'b0;
    a_mover = 1'b0; a_colocar = 1'b0; a_nuevo = 1'b0;
    b_mover = 1'b0; b_colocar = 1'b0; b_nuevo = 1'b0;
    t_mover = 1'b0; t_colocar = 1'b0; t_nuevo = 1'b0;

    @(negedge clk);
    check("rst_board",   a_board,   18'h0);
    check("rst_cursor",  a_cursor,  4'd0);
    check("rst_jugador", a_jugador, 1'b1);
    check("rst_win",     a_win,     1'b0);
    check("rst_draw",    a_draw,    1'b0);
    check("rst_winner",  a_winner,  2'b00);
    check("rst_over",    a_over,    1'b0);
    check("rst_timeout", t_timeout, 1'b0);
    check("rst_illegal", t_illegal, 1'b0);
    rst_n = 1'b1;

    repeat (7) @(negedge clk);
    check("to_edge7",      t_timeout, 1'b0);
    @(negedge clk);
    check("to_edge8",      t_timeout, 1'b1);
    check("to_edge8_jug",  t_jugador, 1'b0);
    @(negedge clk);
    check("to_edge9",      t_timeout, 1'b0);
    repeat (6) @(negedge clk);
    check("to_edge15",     t_timeout, 1'b0);
    @(negedge clk);
    check("to_edge16",     t_timeout, 1'b1);
    check("to_edge16_jug", t_jugador, 1'b1);

    t_new();
    repeat (4) begin
      t_mover = 1'b1; @(negedge clk); t_mover = 1'b0;
    end
    t_colocar = 1'b1; @(negedge clk); t_colocar = 1'b0;
    @(negedge clk);
    check("ill_jug_before", t_jugador, 1'b0);
    @(negedge clk);
    t_colocar = 1'b1; @(negedge clk); t_colocar = 1'b0;
    check("ill_pulse",  t_illegal, 1'b1);
    check("ill_board",  t_board,   18'h00100);
    check("ill_jug",    t_jugador, 1'b0);
    check("ill_cursor", t_cursor,  4'd4);
    check("ill_state",  t_over,    1'b0);
    @(negedge clk);
    check("ill_once",   t_illegal, 1'b0);
    repeat (4) @(negedge clk);
    check("ill_to_early", t_timeout, 1'b0);
    @(negedge clk);
    check("ill_to_fire",  t_timeout, 1'b1);
    check("ill_to_jug",   t_jugador, 1'b1);

    t_new();
    repeat (7) @(negedge clk);
    check("pri_pre", t_timeout, 1'b0);
    t_colocar = 1'b1; @(negedge clk); t_colocar = 1'b0;
    check("pri_no_to", t_timeout, 1'b0);
    check("pri_board", t_board,   18'h00001);
    @(negedge clk);
    check("pri_jug",   t_jugador, 1'b0);
    check("pri_to2",   t_timeout, 1'b0);

    a_new();
    a_put(0); a_put(3); a_put(1); a_put(4);
    while (a_cur != 2) a_mv();
    a_colocar = 1'b1; @(negedge clk); a_colocar = 1'b0;
    check("row_t1_board", a_board, 18'h00295);
    check("row_t1_win",   a_win,   1'b0);
    check("row_t1_over",  a_over,  1'b0);
    @(negedge clk);
    check("row_win",    a_win,    1'b1);
    check("row_winner", a_winner, 2'b01);
    check("row_over",   a_over,   1'b1);
    check("row_draw",   a_draw,   1'b0);
    a_mover = 1'b1; @(negedge clk); a_mover = 1'b0;
    a_colocar = 1'b1; @(negedge clk); a_colocar = 1'b0;
    @(negedge clk);
    check("lock_board",  a_board,   18'h00295);
    check("lock_cursor", a_cursor,  4'd2);
    check("lock_over",   a_over,    1'b1);
    check("lock_ill",    a_illegal, 1'b0);
    a_new();
    check("new_board",  a_board,   18'h0);
    check("new_cursor", a_cursor,  4'd0);
    check("new_jug",    a_jugador, 1'b1);
    check("new_win",    a_win,     1'b0);
    check("new_winner", a_winner,  2'b00);
    check("new_over",   a_over,    1'b0);

    b_new();
    b_put(5); b_put(0); b_put(10);
    check("dg_nowin", b_win, 1'b0);
    b_put(1); b_put(15);
    check("dg_win",    b_win,    1'b1);
    check("dg_winner", b_winner, 2'b01);
    check("dg_over",   b_over,   1'b1);
    check("dg_board",  b_board,  32'h4010_040A);

    b_new();
    b_put(0); b_put(3); b_put(4); b_put(6); b_put(13);
    check("ad_nowin", b_win,     1'b0);
    check("ad_jug",   b_jugador, 1'b0);
    b_put(9);
    check("ad_win",    b_win,    1'b1);
    check("ad_winner", b_winner, 2'b10);
    check("ad_over",   b_over,   1'b1);

    a_new();
    seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    for (int i = 0; i < 8; i++) a_put(seq[i]);
    check("dr_open", a_over, 1'b0);
    a_put(seq[8]);
    check("dr_board",  a_board,  18'h16A59);
    check("dr_draw",   a_draw,   1'b1);
    check("dr_win",    a_win,    1'b0);
    check("dr_winner", a_winner, 2'b00);
    check("dr_over",   a_over,   1'b1);

    a_new();
    seq = '{0, 3, 1, 4, 5, 7, 6, 8, 2};
    for (int i = 0; i < 8; i++) a_put(seq[i]);
    check("lw_open", a_win, 1'b0);
    a_put(seq[8]);
    check("lw_board",  a_board,  18'h29695);
    check("lw_win",    a_win,    1'b1);
    check("lw_draw",   a_draw,   1'b0);
    check("lw_winner", a_winner, 2'b01);

    a_new();
    repeat (8) a_mv();
    check("wrap_8", a_cursor, 4'd8);
    a_mv();
    check("wrap_0", a_cursor, 4'd0);
    a_mover = 1'b1; a_colocar = 1'b1; @(negedge clk);
    a_mover = 1'b0; a_colocar = 1'b0;
    check("mc_board",  a_board,  18'h00001);
    check("mc_cursor", a_cursor, 4'd0);
    @(negedge clk);
    check("mc_jug", a_jugador, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_board", a_board,   18'h0);
    check("arst_jug",   a_jugador, 1'b1);
    check("arst_cur",   a_cursor,  4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gato_game_ctrl.md
Name: gato_game_ctrl

Overview:
Parametrised N×N, K-in-a-row game controller; generalised successor of the 3×3 tic-tac-toe top.
- Contains the board, cursor, turn tracking, per-turn timeout and registered win/draw detection in one clocked block.
- Sits between the debounced button pulses and the display/board renderer.
- Adds behaviour the 3×3 version lacks: draw detection, a winner identity, occupied-cell rejection, a game-over lock and a synchronous new-game request.

Parameters:
- N, 3, board side length; legal 3..8.
- K, 3, consecutive marks needed to win; legal 3..N.
- TURN_CYCLES, 1000, clock cycles allowed per turn before the turn passes; legal ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mover  in  1  single-cycle pulse: advance cursor.
- colocar  in  1  single-cycle pulse: place current player's mark at cursor.
- nuevo  in  1  single-cycle pulse: synchronous new game.
- board  out  2*N*N  cell i at bits [2i+1:2i], row-major; 00 empty, 01 X, 10 O.
- cursor  out  $clog2(N*N)  current cell index.
- jugador  out  1  player to move: 1 = X, 0 = O.
- win  out  1  a K-in-a-row exists; held.
- draw  out  1  board full with no win; held.
- winner  out  2  mark of the winning player (01/10); 00 otherwise.
- game_over  out  1  high in state OVER.
- timeout  out  1  one-cycle pulse when a turn expires.
- illegal  out  1  one-cycle pulse when colocar targets an occupied cell.

Behaviour:
- Reset (rst=0, asynchronous), output values:
  - board all 00, cursor 0, jugador 1 (X moves first).
  - win, draw, game_over, timeout and illegal all 0; winner 00.
  - Turn timer 0; state PLAY.
- nuevo (synchronous): same values as reset on the next edge. Accepted in any state and has priority over every other input.
- States:
  - PLAY: accepts input.
  - CHECK: one cycle; evaluates the board.
  - OVER: locked.
- PLAY, cursor: mover increments cursor; N*N-1 wraps to 0.
- PLAY, colocar on an empty cell at edge t:
  - At t+1: the cell holds the mark of jugador (X→01, O→10); state CHECK; timer cleared.
  - At t+2, if a win exists: win=1, winner=placed mark, state OVER.
  - Else if all cells are non-zero: draw=1, state OVER.
  - Else: jugador toggles, state PLAY.
  - A win on the final empty cell reports win=1 and draw=0 (win has priority).
- PLAY, colocar on an occupied cell: board, jugador and timer are unchanged; illegal pulses for one cycle (t+1).
- mover and colocar in the same cycle: colocar acts at the pre-move cursor; mover is ignored.
- Inputs in CHECK or OVER: mover and colocar are ignored; the cursor is frozen.
- Win detection: any K consecutive cells with equal non-zero value along a row, column, diagonal (↘) or anti-diagonal (↙), at any offset that fits on the board. Implement as combinational generate loops over all windows, registered into win in CHECK.
- Turn timer: counts clock cycles while in PLAY.
  - At count TURN_CYCLES-1 the next edge clears the timer, toggles jugador and pulses timeout for one cycle.
  - A legal colocar in the same cycle as expiry takes priority: placement proceeds, no timeout pulse.
  - The timer does not run in CHECK or OVER.
- Widths: timer $clog2(TURN_CYCLES) bits; cursor $clog2(N*N) bits.
- Registers: all state lives in flops on clk with asynchronous rst; outputs come directly from registers (no combinational paths from input to output).

Test Plan:
- Win in a row, and lock after win:
  - Stimulus: N=3,K=3; X plays 0, O plays 3, X plays 1, O plays 4, X plays 2.
  - Response: two cycles after the last colocar, win=1, winner=01, game_over=1.
  - Stimulus: further mover/colocar.
  - Response: board and cursor unchanged.
- Short-line diagonal on a larger board: N=4,K=3; X at 5,10,15 (O at 0,1) -> win=1, winner=01 after the third X.
- Illegal placement: X at 4, then O colocar at 4 -> illegal pulses once; cell 4 stays 01; jugador stays 0; timer unaffected.
- Timeout: TURN_CYCLES=8; no input after reset -> timeout pulses at cycle 8; jugador=0; pulses again at cycle 16 with jugador=1.
- Draw and winning last move:
  - Stimulus: N=3; X,O,X,O,X,O,X,O,X filling cells 0,1,2,4,3,5,7,6,8.
  - Response: draw=1, win=0, winner=00.
  - Stimulus: a separate sequence whose ninth mark completes a line.
  - Response: win=1, draw=0.
- Cursor wrap and reset mid-game:
  - Stimulus: 9 mover pulses with N=3.
  - Response: cursor returns to 0.
  - Stimulus: rst low asynchronously between edges mid-game.
  - Response: board clears immediately; jugador=1.
  - Stimulus: nuevo in OVER.
  - Response: reset values on the next edge.
